// File: rtl/sha_unpadder.sv
// Strips SHA-style padding from one 512-bit block and returns the message and its length.
// Optional SHA_UNPAD_ERRCNT_EN adds a saturating counter of malformed blocks.
module sha_unpadder #(
  parameter int unsigned MAX_LEN = 447
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_word,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [446:0] msg_data,
  output logic [8:0]   msg_len,
  output logic         err_len,
  output logic         err_pad,
  output logic [15:0]  err_count
);

  localparam logic [8:0] MaxLen = MAX_LEN[8:0];

  typedef enum logic [1:0] {StLoad, StCheck, StOut} state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [511:0]   blk_q, blk_d;
  logic [446:0]   data_q, data_d;
  logic [8:0]     len_q, len_d;
  logic           el_q, el_d;
  logic           ep_q, ep_d;
  logic           accept;
  logic           handshake;

  logic [63:0]    l_full;
  logic [8:0]     l9;
  logic [8:0]     shamt;
  logic [447:0]   upper;
  logic [447:0]   low_mask;
  logic [447:0]   marker;
  logic [447:0]   shifted;
  logic           chk_len_err;
  logic           chk_pad_err;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StLoad;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:  if (accept && (cnt_q == 4'd15)) state_d = StCheck;
      StCheck: state_d = StOut;
      StOut:   if (handshake) state_d = StLoad;
      default: state_d = StLoad;
    endcase
  end

  // Output logic; flags are masked so they read 0 whenever no result is presented
  always_comb begin
    in_ready  = (state_q == StLoad);
    out_valid = (state_q == StOut);
    msg_data  = data_q;
    msg_len   = len_q;
    err_len   = el_q & out_valid;
    err_pad   = ep_q & out_valid;
  end

  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;

  // Padding check: message fills upper[447:448-L], marker at upper[447-L], zeros below it.
  always_comb begin
    l_full      = blk_q[63:0];
    l9          = l_full[8:0];
    upper       = blk_q[511:64];
    chk_len_err = (|l_full[63:9]) || (l9 > MaxLen);
    low_mask    = {448{1'b1}} >> l9;
    marker      = {1'b1, 447'b0} >> l9;
    chk_pad_err = !chk_len_err && ((upper & low_mask) != marker);
    shamt       = 9'd448 - l9;
    shifted     = upper >> shamt;
  end

  always_comb begin
    cnt_d  = cnt_q;
    blk_d  = blk_q;
    data_d = data_q;
    len_d  = len_q;
    el_d   = el_q;
    ep_d   = ep_q;
    if (accept) begin
      cnt_d = cnt_q + 4'd1;
      blk_d = {blk_q[479:0], in_word};
    end
    if (state_q == StCheck) begin
      el_d = chk_len_err;
      ep_d = chk_pad_err;
      if (chk_len_err || chk_pad_err) begin
        data_d = '0;
        len_d  = '0;
      end else begin
        data_d = shifted[446:0];
        len_d  = l9;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      blk_q  <= '0;
      data_q <= '0;
      len_q  <= '0;
      el_q   <= 1'b0;
      ep_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      blk_q  <= blk_d;
      data_q <= data_d;
      len_q  <= len_d;
      el_q   <= el_d;
      ep_q   <= ep_d;
    end
  end

`ifdef SHA_UNPAD_ERRCNT_EN
  logic [15:0] ecnt_q, ecnt_d;

  always_comb begin
    ecnt_d = ecnt_q;
    if (handshake && (el_q || ep_q) && (ecnt_q != 16'hFFFF)) begin
      ecnt_d = ecnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ecnt_q <= '0;
    end else begin
      ecnt_q <= ecnt_d;
    end
  end

  assign err_count = ecnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_sha_unpadder.sv
// Directed bench for sha_unpadder: expected results queued at stimulus time, popped at output.
module tb_sha_unpadder;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_word;
  logic         out_valid;
  logic         out_ready;
  logic [446:0] msg_data;
  logic [8:0]   msg_len;
  logic         err_len;
  logic         err_pad;
  logic [15:0]  err_count;

  sha_unpadder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .msg_data  (msg_data),
    .msg_len   (msg_len),
    .err_len   (err_len),
    .err_pad   (err_pad),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [446:0] data;
    logic [8:0]   len;
    logic         el;
    logic         ep;
  } exp_t;

  exp_t         sb[$];
  logic [31:0]  blk[16];
  int           checks = 0;
  int           failures = 0;
  logic [15:0]  exp_ecnt = '0;
  logic         last_err;
  logic [446:0] exp_long;

  task automatic check(input string tag, input logic [446:0] obs, input logic [446:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [446:0] d, input logic [8:0] l, input logic el, input logic ep);
    exp_t e;
    e.data = d;
    e.len  = l;
    e.el   = el;
    e.ep   = ep;
    sb.push_back(e);
  endtask

  task automatic set_good();
    blk[0] = 32'h61626380;
    for (int i = 1; i < 15; i++) blk[i] = 32'h0;
    blk[15] = 32'h00000018;
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_word  = blk[i];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_word  = '0;
  endtask

  task automatic compare_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty observed=result expected=none", tag);
    end else begin
      e = sb.pop_front();
      last_err = e.el || e.ep;
      check({tag, "_data"}, msg_data, e.data);
      check({tag, "_len"}, 447'(msg_len), 447'(e.len));
      check({tag, "_err_len"}, 447'(err_len), 447'(e.el));
      check({tag, "_err_pad"}, 447'(err_pad), 447'(e.ep));
    end
  endtask

  // Full block with out_ready=1: 2-cycle latency, then handshake and return to LOAD.
  task automatic run_block(input string tag);
    send(16);
    check({tag, "_early_valid"}, 447'(out_valid), 447'(1'b0));
    @(posedge clk);
    #1;
    check({tag, "_latency"}, 447'(out_valid), 447'(1'b1));
    compare_result(tag);
    @(posedge clk);
    #1;
`ifdef SHA_UNPAD_ERRCNT_EN
    if (last_err && exp_ecnt != 16'hFFFF) exp_ecnt = exp_ecnt + 16'd1;
`endif
    check({tag, "_post_valid"}, 447'(out_valid), 447'(1'b0));
    check({tag, "_post_ready"}, 447'(in_ready), 447'(1'b1));
    check({tag, "_post_flags"}, 447'({err_len, err_pad}), 447'(2'b00));
    check({tag, "_err_count"}, 447'(err_count), 447'(exp_ecnt));
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_in_ready", 447'(in_ready), 447'(1'b1));
    check("rst_out_valid", 447'(out_valid), 447'(1'b0));
    check("rst_msg_data", msg_data, '0);
    check("rst_msg_len", 447'(msg_len), '0);
    check("rst_flags", 447'({err_len, err_pad}), '0);
    check("rst_err_count", 447'(err_count), '0);

    set_good();
    push(447'h616263, 9'd24, 1'b0, 1'b0);
    run_block("good");

    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0] = 32'h80000000;
    push('0, 9'd0, 1'b0, 1'b0);
    run_block("len0");

    exp_long = '0;
    for (int i = 0; i < 13; i++) begin
      blk[i]   = 32'hA5C30000 + i;
      exp_long = (exp_long << 32) | 447'(blk[i]);
    end
    blk[13]  = 32'hDEADBEEF;
    exp_long = (exp_long << 31) | 447'(blk[13] >> 1);
    blk[14]  = 32'h0;
    blk[15]  = 32'h000001BF;
    push(exp_long, 9'd447, 1'b0, 1'b0);
    run_block("len447");

    set_good();
    blk[15] = 32'h000001C0;
    push('0, 9'd0, 1'b1, 1'b0);
    run_block("err_len");

    set_good();
    blk[0] = 32'h61626300;
    push('0, 9'd0, 1'b0, 1'b1);
    run_block("no_marker");

    set_good();
    blk[7] = 32'h00000001;
    push('0, 9'd0, 1'b0, 1'b1);
    run_block("stray_one");

    // Backpressure: result must hold while out_ready is low
    set_good();
    push(447'h616263, 9'd24, 1'b0, 1'b0);
    out_ready = 1'b0;
    send(16);
    @(posedge clk);
    #1;
    check("bp_latency", 447'(out_valid), 447'(1'b1));
    compare_result("bp");
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", 447'(out_valid), 447'(1'b1));
      check("bp_hold_ready", 447'(in_ready), 447'(1'b0));
      check("bp_hold_data", msg_data, 447'h616263);
      check("bp_hold_len", 447'(msg_len), 447'(9'd24));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 447'(out_valid), 447'(1'b0));
    check("bp_release_ready", 447'(in_ready), 447'(1'b1));

    // Reset mid-block drops partial words
    set_good();
    blk[0] = 32'hFFFFFFFF;
    send(7);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    exp_ecnt = '0;
    check("midrst_in_ready", 447'(in_ready), 447'(1'b1));
    check("midrst_err_count", 447'(err_count), 447'(exp_ecnt));
    set_good();
    push(447'h616263, 9'd24, 1'b0, 1'b0);
    run_block("after_midrst");

    // Reset while a malformed result is pending
    set_good();
    blk[15] = 32'h000001C0;
    push('0, 9'd0, 1'b1, 1'b0);
    out_ready = 1'b0;
    send(16);
    @(posedge clk);
    #1;
    check("outrst_valid", 447'(out_valid), 447'(1'b1));
    compare_result("outrst");
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("outrst_dropped", 447'(out_valid), 447'(1'b0));
    check("outrst_flags", 447'({err_len, err_pad}), '0);
    check("outrst_err_count", 447'(err_count), '0);
    out_ready = 1'b1;
    set_good();
    push(447'h616263, 9'd24, 1'b0, 1'b0);
    run_block("after_outrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
